// File: rtl/bullet_ctrl.sv
// Player bullet controller: launches on a fire edge sampled at frame ticks and
// climbs each frame. A hit turns the bullet into a timed explosion.
module bullet_ctrl #(
  parameter logic [9:0] START_Y        = 10'd440,
  parameter logic [9:0] SPEED          = 10'd4,
  parameter logic [9:0] X_OFFSET       = 10'd16,
  parameter logic [9:0] X_MAX          = 10'd639,
  parameter logic [3:0] EXPLODE_FRAMES = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       pixel_0_line_0,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic       hit,
  output logic       bullet_active,
  output logic       explode_active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic [7:0] hit_count,
  output logic       miss
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLY     = 2'd1,
    S_EXPLODE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_fire_q;
  logic        r_pending;
  logic        r_miss;
  logic [3:0]  r_frames;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [7:0]  r_hits;

  logic        w_tick;
  logic        w_launch;
  logic        w_go;
  logic        w_hit_fly;
  logic        w_offscreen;
  logic        w_explode_done;
  logic [10:0] w_x_sum;
  logic [9:0]  w_x_launch;

  assign w_tick    = enb & pixel_0_line_0;
  assign w_launch  = w_tick & fire & ~r_fire_q;
  assign w_go      = (r_state == S_IDLE) & w_tick & (w_launch | r_pending);
  // A hit outranks the off-screen check when both land on the same tick.
  assign w_hit_fly      = (r_state == S_FLY) & enb & hit;
  assign w_offscreen    = (r_state == S_FLY) & w_tick & (r_y < SPEED) & ~w_hit_fly;
  assign w_explode_done = (r_state == S_EXPLODE) & w_tick & (r_frames <= 4'd1);

  // Sum in 11 bits so a right-edge player cannot wrap the bullet to the left.
  assign w_x_sum    = {1'b0, player_x} + {1'b0, X_OFFSET};
  assign w_x_launch = (w_x_sum > {1'b0, X_MAX}) ? X_MAX : w_x_sum[9:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) w_state_nxt = S_FLY;
      end
      S_FLY: begin
        if (w_hit_fly)        w_state_nxt = S_EXPLODE;
        else if (w_offscreen) w_state_nxt = S_IDLE;
      end
      S_EXPLODE: begin
        if (w_explode_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bullet_active  = (r_state == S_FLY);
    explode_active = (r_state == S_EXPLODE);
    bullet_x       = r_x;
    bullet_y       = r_y;
    hit_count      = r_hits;
    miss           = r_miss;
  end

  // Fire edge detector and the one-deep launch buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fire_q  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_tick) r_fire_q <= fire;
      if (r_state == S_IDLE) begin
        if (w_go) r_pending <= 1'b0;
      end else if (w_launch) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x <= 10'd0;
      r_y <= 10'd0;
    end else if (w_go) begin
      r_x <= w_x_launch;
      r_y <= START_Y;
    end else if ((r_state == S_FLY) && w_tick && !w_hit_fly && !w_offscreen) begin
      r_y <= r_y - SPEED;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frames <= 4'd0;
      r_hits   <= 8'd0;
      r_miss   <= 1'b0;
    end else begin
      r_miss <= w_offscreen;
      if (w_hit_fly) begin
        r_frames <= EXPLODE_FRAMES;
        if (r_hits != 8'hFF) r_hits <= r_hits + 8'd1;
      end else if ((r_state == S_EXPLODE) && w_tick && (r_frames != 4'd0)) begin
        r_frames <= r_frames - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: a hand-derived vector table through a scoreboard queue,
// then directed sequences for miss, pending relaunch, hit timing, reset and saturation.
module tb_bullet_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       pixel_0_line_0;
  logic       fire;
  logic [9:0] player_x;
  logic       hit;
  logic       bullet_active;
  logic       explode_active;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic [7:0] hit_count;
  logic       miss;

  int n_tests = 0;
  int n_fail  = 0;

  bullet_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .enb            (enb),
    .pixel_0_line_0 (pixel_0_line_0),
    .fire           (fire),
    .player_x       (player_x),
    .hit            (hit),
    .bullet_active  (bullet_active),
    .explode_active (explode_active),
    .bullet_x       (bullet_x),
    .bullet_y       (bullet_y),
    .hit_count      (hit_count),
    .miss           (miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tk;
    logic       fi;
    logic       ht;
    logic       en;
    logic [9:0] px;
    logic       act;
    logic       ex;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] hc;
    logic       ms;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(logic tk, logic fi, logic ht, logic en, logic [9:0] px,
                              logic act, logic ex, logic [9:0] x, logic [9:0] y,
                              logic [7:0] hc, logic ms);
    vec_t v;
    v.tk = tk; v.fi = fi; v.ht = ht; v.en = en; v.px = px;
    v.act = act; v.ex = ex; v.x = x; v.y = y; v.hc = hc; v.ms = ms;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic tk, input logic fi, input logic ht, input logic en,
                     input logic [9:0] px);
    pixel_0_line_0 = tk;
    fire           = fi;
    hit            = ht;
    enb            = en;
    player_x       = px;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic fi);
    cyc(1'b1, fi, 1'b0, 1'b1, 10'd100);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pixel_0_line_0 = 1'b0; fire = 1'b0; hit = 1'b0; enb = 1'b1; player_x = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".active"},  bullet_active,  0);
    chk({name, ".explode"}, explode_active, 0);
    chk({name, ".x"},       bullet_x,       0);
    chk({name, ".y"},       bullet_y,       0);
    chk({name, ".hits"},    hit_count,      0);
    chk({name, ".miss"},    miss,           0);
  endtask

  initial begin
    int misses;
    int frames;
    vec_t e;

    // Vector table: inputs for one clock, outputs expected just after that edge.
    vecs.push_back(mk(0,0,0,1,100, 0,0,  0,  0,0,0));
    vecs.push_back(mk(1,1,0,1,100, 1,0,116,440,0,0)); // launch at 100+16
    vecs.push_back(mk(0,0,0,1,100, 1,0,116,440,0,0)); // no tick, no motion
    vecs.push_back(mk(1,0,0,1,200, 1,0,116,436,0,0)); // x fixed while flying
    vecs.push_back(mk(1,0,0,0,200, 1,0,116,436,0,0)); // enb low freezes
    vecs.push_back(mk(0,0,1,0,200, 1,0,116,436,0,0)); // hit ignored with enb low
    vecs.push_back(mk(0,0,1,1,200, 0,1,116,436,1,0)); // mid-frame hit
    vecs.push_back(mk(0,0,1,1,200, 0,1,116,436,1,0)); // hit ignored in explode
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1,0,0,1,200, 0,1,116,436,1,0));
    vecs.push_back(mk(1,0,0,1,200, 0,0,116,436,1,0)); // 8th tick ends explosion
    vecs.push_back(mk(1,1,0,1,630, 1,0,639,440,1,0)); // clamp to X_MAX
    vecs.push_back(mk(1,0,0,1,630, 1,0,639,436,1,0));
    vecs.push_back(mk(1,1,0,1,630, 1,0,639,432,1,0)); // event buffered, no relaunch
    vecs.push_back(mk(1,0,0,1,630, 1,0,639,428,1,0));
    vecs.push_back(mk(0,0,1,1,630, 0,1,639,428,2,0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1,0,0,1,630, 0,1,639,428,2,0));
    vecs.push_back(mk(1,0,0,1,630, 0,0,639,428,2,0));
    vecs.push_back(mk(0,0,0,1,50,  0,0,639,428,2,0)); // never launches off-tick
    vecs.push_back(mk(1,0,0,1,50,  1,0, 66,440,2,0)); // pending relaunch
    vecs.push_back(mk(1,0,0,1,50,  1,0, 66,436,2,0));

    do_reset();
    chk_zero("reset");

    foreach (vecs[i]) begin
      pixel_0_line_0 = vecs[i].tk;
      fire           = vecs[i].fi;
      hit            = vecs[i].ht;
      enb            = vecs[i].en;
      player_x       = vecs[i].px;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_tests++;
      if ({bullet_active, explode_active, bullet_x, bullet_y, hit_count, miss} !==
          {e.act, e.ex, e.x, e.y, e.hc, e.ms}) begin
        n_fail++;
        $display("FAIL vec%0d: got act=%0b ex=%0b x=%0d y=%0d hc=%0d miss=%0b expected act=%0b ex=%0b x=%0d y=%0d hc=%0d miss=%0b",
                 i, bullet_active, explode_active, bullet_x, bullet_y, hit_count, miss,
                 e.act, e.ex, e.x, e.y, e.hc, e.ms);
      end
    end

    // Full flight to a miss, with two fire events during it.
    do_reset();
    tick(1'b1);
    chk("miss.launch_y", bullet_y, 440);
    misses = 0;
    for (int k = 1; k <= 110; k++) begin
      tick((k == 2) || (k == 4));
      if (miss) misses++;
    end
    chk("miss.y_at_top", bullet_y, 0);
    chk("miss.still_fly", bullet_active, 1);
    chk("miss.early", misses, 0);
    tick(1'b0);
    chk("miss.idle", bullet_active, 0);
    chk("miss.pulse", miss, 1);
    chk("miss.hits", hit_count, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 10'd100);
    chk("miss.one_clock", miss, 0);
    tick(1'b0);
    chk("pend.relaunch", bullet_active, 1);
    chk("pend.relaunch_y", bullet_y, 440);
    misses = 0;
    for (int k = 0; k < 111; k++) begin
      tick(1'b0);
      if (miss) misses++;
    end
    chk("pend.second_miss", misses, 1);
    tick(1'b0);
    chk("pend.dropped", bullet_active, 0);

    // Hit and off-screen on the same tick.
    do_reset();
    tick(1'b1);
    for (int k = 0; k < 110; k++) tick(1'b0);
    chk("race.y", bullet_y, 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 10'd100);
    chk("race.explode", explode_active, 1);
    chk("race.no_miss", miss, 0);
    chk("race.hits", hit_count, 1);

    // Hit at y=300 and explosion length.
    do_reset();
    tick(1'b1);
    for (int k = 0; k < 35; k++) tick(1'b0);
    chk("hit.y_before", bullet_y, 300);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 10'd100);
    chk("hit.explode", explode_active, 1);
    chk("hit.hits", hit_count, 1);
    frames = 0;
    for (int k = 0; k < 20 && explode_active; k++) begin
      tick(1'b0);
      frames++;
      if (explode_active) chk("hit.y_held", bullet_y, 300);
    end
    chk("hit.frames", frames, 8);

    // Global enable low for five ticks freezes the flight.
    do_reset();
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'd100);
    chk("enb.frozen_y", bullet_y, 432);
    chk("enb.still_fly", bullet_active, 1);
    tick(1'b0);
    chk("enb.resume_y", bullet_y, 428);

    // Asynchronous reset mid-flight.
    do_reset();
    tick(1'b1);
    tick(1'b0);
    rst = 1'b0;
    #1;
    chk_zero("rst_fly");
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1'b0);
    chk("rst.no_relaunch", bullet_active, 0);
    tick(1'b1);
    chk("rst.resume", bullet_active, 1);
    chk("rst.resume_y", bullet_y, 440);

    // Hit counter saturation.
    do_reset();
    for (int n = 1; n <= 256; n++) begin
      tick(1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 10'd100);
      for (int k = 0; k < 8; k++) tick(1'b0);
      if (n == 255) chk("sat.255", hit_count, 255);
    end
    chk("sat.hold", hit_count, 255);
    chk("sat.idle", bullet_active | explode_active, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bullet_ctrl.md
BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 The module SHALL have parameter START_Y, default 10'd440, meaning the row at which a new bullet spawns.
REQ-002 The module SHALL have parameter SPEED, default 10'd4, meaning rows moved up per frame tick.
REQ-003 The module SHALL have parameter X_OFFSET, default 10'd16, meaning the column offset added to player_x at launch.
REQ-004 The module SHALL have parameter X_MAX, default 10'd639, meaning the maximum legal bullet column.
REQ-005 The module SHALL have parameter EXPLODE_FRAMES, default 4'd8, meaning frame ticks spent in the explosion state.
REQ-006 The module SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit, the asynchronous active-low reset.
REQ-008 The module SHALL have port enb, input, 1 bit, the global game enable.
REQ-009 The module SHALL have port pixel_0_line_0, input, 1 bit, the frame tick; frame_tick is defined as enb && pixel_0_line_0.
REQ-010 The module SHALL have port fire, input, 1 bit, the cooldown-limited fire level from the fire trigger, held high for at most one frame.
REQ-011 The module SHALL have port player_x, input, 10 bits, the current player column.
REQ-012 The module SHALL have port hit, input, 1 bit, the collision flag from the collision logic, valid on any clock cycle.
REQ-013 The module SHALL have port bullet_active, output, 1 bit, high while a bullet is flying.
REQ-014 The module SHALL have port explode_active, output, 1 bit, high while the explosion is shown.
REQ-015 The module SHALL have ports bullet_x and bullet_y, outputs, 10 bits each, the current bullet position.
REQ-016 The module SHALL have port hit_count, output, 8 bits, the number of hits since reset.
REQ-017 The module SHALL have port miss, output, 1 bit, a one-clock pulse when a bullet leaves the top of the screen.

Function
REQ-018 FSM states SHALL be IDLE, FLY and EXPLODE; bullet_active = (state==FLY) and explode_active = (state==EXPLODE).
REQ-019 fire SHALL be sampled only on frame_tick cycles into fire_q; a launch event SHALL be fire && !fire_q on a frame_tick.
REQ-020 A launch event in FLY or EXPLODE SHALL set pending; a second event while pending is set SHALL be dropped (one-deep buffer).
REQ-021 IDLE->FLY on a frame_tick with a launch event or pending; at that edge bullet_y=START_Y, bullet_x=min(player_x+X_OFFSET, X_MAX) computed in 11 bits, and pending clears.
REQ-022 In FLY on frame_tick: if bullet_y < SPEED then ->IDLE with miss=1 for that clock, else bullet_y -= SPEED; bullet_x SHALL stay fixed.
REQ-023 In FLY, hit=1 on any cycle with enb=1 SHALL take ->EXPLODE at the next edge, load the 4-bit frame counter with EXPLODE_FRAMES, and increment hit_count saturating at 255.
REQ-024 If hit and the off-screen condition occur on the same frame_tick cycle, hit SHALL win: EXPLODE, no miss pulse.
REQ-025 In EXPLODE, bullet_x and bullet_y SHALL hold the hit position; each frame_tick decrements the counter, and the tick with counter==1 ->IDLE.
REQ-026 In IDLE or EXPLODE, hit SHALL be ignored.
REQ-027 With enb=0, no state, position, counter, pending or fire_q change SHALL occur, and hit_count SHALL hold.
REQ-028 A pending launch SHALL fire on the first frame_tick after return to IDLE; IDLE never launches off-tick.

Reset
REQ-029 rst=0 SHALL asynchronously force: state IDLE, bullet_x=0, bullet_y=0, hit_count=0, miss=0, pending=0, fire_q=0, frame counter 0.
REQ-030 Reset asserted mid-flight or mid-explosion SHALL abort with no miss pulse and no hit_count change; operation resumes on the first frame_tick after release.

Verification
REQ-031 Launch: player_x=100, fire high for one frame -> next tick bullet_active=1, bullet_x=116, bullet_y=440; after 10 more ticks bullet_y=400.
REQ-032 Clamp: player_x=630 launch -> bullet_x=639.
REQ-033 Miss: flight from 440 with SPEED=4 -> 110 decrements to y=0, next tick IDLE with exactly one miss pulse, hit_count unchanged.
REQ-034 Hit: hit pulsed one cycle mid-frame at y=300 -> EXPLODE next edge, position held at y=300, hit_count=1, IDLE after exactly 8 ticks.
REQ-035 Pending: two fire events during a flight -> exactly one relaunch on the first tick after IDLE; the second event is dropped.
REQ-036 Edge cases: hit and y<SPEED on the same tick -> EXPLODE with no miss; rst low mid-FLY -> all outputs zero immediately; enb=0 for 5 ticks -> position frozen.
